// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int DEFAULT_DEPTH = 64;
    localparam int CSUM_W        = 8;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; the output already
// includes the byte being loaded this cycle so the 4th byte can be written at once.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  lane,
    input  logic        load,
    output logic [31:0] word
);

    logic [31:0] lanes_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples its inputs from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q <= '0;
        end else if (load) begin
            lanes_q[{lane, 3'b000} +: 8] <= byte_in;
        end
    end

    // NOTE: default assignment first so no path leaves word unassigned (no latch).
    always_comb begin
        word = lanes_q;
        if (load) begin
            word[{lane, 3'b000} +: 8] = byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a header/payload/checksum byte stream, writes 32-bit words into
// instruction memory and releases the processor only after a good checksum.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_t              state;
    logic [7:0]          n_words;
    logic [7:0]          word_idx;
    logic [1:0]          lane;
    logic [CSUM_W-1:0]   csum;
    logic [31:0]         packed_word;
    logic                accept;
    logic                data_accept;

    assign in_ready    = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state == ST_DATA);

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .byte_in (in_data),
        .lane    (lane),
        .load    (data_accept),
        .word    (packed_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_HDR;
            n_words   <= '0;
            word_idx  <= '0;
            lane      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        n_words <= in_data;
                        if (in_data == 8'd0 || 32'(in_data) > 32'(DEPTH)) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum <= csum ^ in_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {22'd0, word_idx, 2'b00};
                            mem_wdata <= packed_word;
                            word_idx  <= word_idx + 8'd1;
                            if (word_idx == n_words - 8'd1) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE and ERR hold until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: streams are scored against a word-level
// model of the load protocol (expected writes list plus final outcome).
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  payload[$];
    int          consec_we = 0;
    int          both_set  = 0;
    logic        prev_we   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
            end
            if (mem_we && prev_we) consec_we++;
            if (done && error) both_set++;
            prev_we = mem_we;
        end
    end

    task automatic do_reset(input bit check_outputs);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        got_addr.delete();
        got_data.delete();
        if (check_outputs) begin
            check("rst_mem_we",    32'(mem_we),    32'd0);
            check("rst_mem_addr",  mem_addr,       32'd0);
            check("rst_mem_wdata", mem_wdata,      32'd0);
            check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            check("rst_done",      32'(done),      32'd0);
            check("rst_error",     32'(error),     32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte's edge.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int gap;
        gap = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 4)) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_load(input string name, input logic [7:0] hdr,
                            input logic [7:0] csum_byte, input int gap_pct);
        int         n;
        bit         hdr_ok;
        bit         exp_done;
        logic [7:0] x;
        n      = int'(hdr);
        hdr_ok = (n >= 1) && (n <= DEPTH);
        exp_addr.delete();
        exp_data.delete();
        x = 8'h00;
        if (hdr_ok) begin
            for (int k = 0; k < n; k++) begin
                exp_addr.push_back(32'(4 * k));
                exp_data.push_back(32'(payload[4*k])          |
                                   (32'(payload[4*k+1]) << 8)  |
                                   (32'(payload[4*k+2]) << 16) |
                                   (32'(payload[4*k+3]) << 24));
            end
            for (int i = 0; i < 4 * n; i++) x = x ^ payload[i];
        end
        exp_done = hdr_ok && (x == csum_byte);

        do_reset(1'b0);
        send_byte(hdr, gap_pct);
        if (!hdr_ok) begin
            check({name, "_hdr_error"},    32'(error),     32'd1);
            check({name, "_hdr_in_ready"}, 32'(in_ready),  32'd0);
            check({name, "_hdr_done"},     32'(done),      32'd0);
            check({name, "_hdr_cpu_rst"},  32'(cpu_reset), 32'd1);
            send_byte(8'h01, 0);
            send_byte(8'h07, 0);
            repeat (3) @(posedge clk);
            #1;
            check({name, "_hdr_writes"}, 32'(got_addr.size()), 32'd0);
            check({name, "_hdr_sticky"}, 32'(error), 32'd1);
            return;
        end

        for (int i = 0; i < 4 * n; i++) send_byte(payload[i], gap_pct);
        send_byte(csum_byte, gap_pct);
        check({name, "_done"},      32'(done),      32'(exp_done));
        check({name, "_error"},     32'(error),     32'(!exp_done));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({name, "_in_ready"},  32'(in_ready),  32'd0);

        // Bytes offered after the end must be ignored.
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_sticky_done"},  32'(done),  32'(exp_done));
        check({name, "_sticky_error"}, 32'(error), 32'(!exp_done));
        check({name, "_wr_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_wr%0d_data", name, i), got_data[i], exp_data[i]);
        end
    endtask

    function automatic logic [7:0] xor_payload(input int nbytes);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < nbytes; i++) x = x ^ payload[i];
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] cs;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        do_reset(1'b1);

        payload = '{8'h07, 8'h00, 8'h00, 8'h00};
        run_load("single", 8'h01, 8'h07, 0);

        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load("two_good", 8'h02, 8'h08, 50);
        run_load("two_bad",  8'h02, 8'h09, 50);

        run_load("hdr_zero", 8'h00, 8'h00, 0);
        run_load("hdr_65",   8'd65, 8'h00, 0);

        // Abort an N=2 load after 6 payload bytes, then a clean single-word load.
        do_reset(1'b0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 30);
        payload = '{8'h07, 8'h00, 8'h00, 8'h00};
        run_load("after_abort", 8'h01, 8'h07, 30);

        payload.delete();
        for (int i = 0; i < 4 * DEPTH; i++) payload.push_back(8'(i));
        run_load("full", 8'(DEPTH), 8'h00, 20);

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, DEPTH));
            payload.delete();
            for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
            cs = xor_payload(4 * n);
            if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            run_load($sformatf("rand%0d", t), 8'(n), cs, int'($urandom_range(0, 60)));
        end

        for (int t = 0; t < 2; t++) begin
            run_load($sformatf("rand_hdr%0d", t), 8'($urandom_range(DEPTH + 1, 255)), 8'h00, 0);
        end

        check("no_consecutive_we", 32'(consec_we), 32'd0);
        check("done_error_exclusive", 32'(both_set), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
